// File: rtl/usb_tx_controller.sv
// -----------------------------------------------------------------------------
// usb_tx_controller
//
// Sequences the USB transmit encoder for one packet at a time: a clock-divided
// bit timer paces the slots, the SYNC pattern (0x80 LSB-first) is sent first,
// payload bytes are pulled from the upstream byte source and serialised
// LSB-first with bit stuffing, and the packet is closed with EOP
// (two SE0 slots followed by one J slot).
//
// Parameters
//   CLKS_PER_BIT  clocks per USB bit slot (>= 2)
//   STUFF_LIMIT   consecutive transmitted 1s that force a stuffed 0
//
// Ports
//   clk            system clock
//   n_rst          asynchronous, active-low reset
//   tx_start_i     request to send a packet; sampled only in IDLE
//   tx_data_i      payload byte from the source
//   tx_valid_i     tx_data_i / tx_last_i valid
//   tx_last_i      current byte is the final payload byte
//   tx_ready_o     one-clock pop strobe; the byte is latched this cycle
//   enc_data_o     bit presented to the encoder (0 = toggle line)
//   enc_new_bit_o  strobe on the final clock of each SYNC/DATA/STUFF slot
//   enc_eop_o      force SE0 on the encoder
//   enc_idle_o     force J on the encoder
//   tx_busy_o      packet in progress
//   tx_done_o      one-clock strobe, packet finished normally
//   tx_error_o     one-clock strobe, underflow abort
// -----------------------------------------------------------------------------
module usb_tx_controller #(
  parameter int CLKS_PER_BIT = 8,
  parameter int STUFF_LIMIT  = 6
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       tx_start_i,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  input  logic       tx_last_i,
  output logic       tx_ready_o,
  output logic       enc_data_o,
  output logic       enc_new_bit_o,
  output logic       enc_eop_o,
  output logic       enc_idle_o,
  output logic       tx_busy_o,
  output logic       tx_done_o,
  output logic       tx_error_o
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int OW = $clog2(STUFF_LIMIT + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(CLKS_PER_BIT - 1);
  localparam logic [OW-1:0] ONES_LIM = OW'(STUFF_LIMIT);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SYNC    = 3'd1,
    ST_DATA    = 3'd2,
    ST_STUFF   = 3'd3,
    ST_EOP_SE0 = 3'd4,
    ST_EOP_J   = 3'd5
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;      // SYNC/DATA bit index, reused as SE0 slot index
  logic [7:0]      shreg_q, shreg_d;
  logic            last_q, last_d;    // byte in the shift register is the final one
  logic [OW-1:0]   ones_q, ones_d;
  logic            fin_q, fin_d;      // final data bit sent; a pending STUFF leads to EOP
  logic            abort_q, abort_d;  // underflow seen; suppresses tx_done

  logic            enc_data_q, enc_data_d;
  logic            enc_new_bit_q, enc_new_bit_d;
  logic            enc_eop_q, enc_eop_d;
  logic            enc_idle_q, enc_idle_d;
  logic            tx_busy_q, tx_busy_d;
  logic            tx_done_q, tx_done_d;

  logic            slot_end_s;
  logic            cur_bit_s;
  logic            stuff_req_s;
  logic            pop_s;
  logic            err_s;

  assign slot_end_s  = (cnt_q == CNT_MAX);
  // A 1 at this slot end that brings the run of ones up to the limit.
  assign stuff_req_s = cur_bit_s && ((ones_q + OW'(1)) == ONES_LIM);

  // Bit currently on the wire for the running slot.
  always_comb begin
    case (state_q)
      ST_SYNC:  cur_bit_s = (idx_q == 3'd7);
      ST_DATA:  cur_bit_s = shreg_q[0];
      ST_STUFF: cur_bit_s = 1'b0;
      default:  cur_bit_s = 1'b1;
    endcase
  end

  // Next-state logic: slot sequencing, byte pops, stuffing and abort.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    last_d  = last_q;
    ones_d  = ones_q;
    fin_d   = fin_q;
    abort_d = abort_q;
    pop_s   = 1'b0;
    err_s   = 1'b0;

    if (state_q == ST_IDLE) begin
      cnt_d = {CW{1'b0}};
    end else if (slot_end_s) begin
      cnt_d = {CW{1'b0}};
    end else begin
      cnt_d = cnt_q + CW'(1);
    end

    case (state_q)
      ST_IDLE: begin
        idx_d   = 3'd0;
        ones_d  = {OW{1'b0}};
        fin_d   = 1'b0;
        abort_d = 1'b0;
        if (tx_start_i && tx_valid_i) begin
          shreg_d = tx_data_i;
          last_d  = tx_last_i;
          pop_s   = 1'b1;
          state_d = ST_SYNC;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_SYNC: begin
        if (slot_end_s) begin
          ones_d = cur_bit_s ? (ones_q + OW'(1)) : {OW{1'b0}};
          idx_d  = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            state_d = stuff_req_s ? ST_STUFF : ST_DATA;
          end else begin
            state_d = ST_SYNC;
          end
        end else begin
          state_d = ST_SYNC;
        end
      end

      ST_DATA: begin
        if (slot_end_s) begin
          ones_d  = cur_bit_s ? (ones_q + OW'(1)) : {OW{1'b0}};
          shreg_d = {1'b0, shreg_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q != 3'd7) begin
            state_d = stuff_req_s ? ST_STUFF : ST_DATA;
          end else if (last_q) begin
            fin_d   = 1'b1;
            state_d = stuff_req_s ? ST_STUFF : ST_EOP_SE0;
          end else if (tx_valid_i) begin
            // The pop happens at this slot end even when a STUFF slot follows.
            pop_s   = 1'b1;
            shreg_d = tx_data_i;
            last_d  = tx_last_i;
            state_d = stuff_req_s ? ST_STUFF : ST_DATA;
          end else begin
            // Source ran dry mid-packet: abort straight into EOP.
            err_s   = 1'b1;
            abort_d = 1'b1;
            state_d = ST_EOP_SE0;
          end
        end else begin
          state_d = ST_DATA;
        end
      end

      ST_STUFF: begin
        if (slot_end_s) begin
          ones_d  = {OW{1'b0}};
          state_d = fin_q ? ST_EOP_SE0 : ST_DATA;
        end else begin
          state_d = ST_STUFF;
        end
      end

      ST_EOP_SE0: begin
        if (slot_end_s) begin
          if (idx_q == 3'd1) begin
            idx_d   = 3'd0;
            state_d = ST_EOP_J;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = ST_EOP_SE0;
          end
        end else begin
          state_d = ST_EOP_SE0;
        end
      end

      ST_EOP_J: begin
        if (slot_end_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_EOP_J;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = {CW{1'b0}};
      end
    endcase
  end

  // Encoder-facing outputs decoded from the next state so they can be registered
  // and still line up with the slot they describe.
  always_comb begin
    case (state_d)
      ST_SYNC:  enc_data_d = (idx_d == 3'd7);
      ST_DATA:  enc_data_d = shreg_d[0];
      ST_STUFF: enc_data_d = 1'b0;
      default:  enc_data_d = 1'b1;
    endcase
    enc_new_bit_d = ((state_d == ST_SYNC) || (state_d == ST_DATA) || (state_d == ST_STUFF)) &&
                    (cnt_d == CNT_MAX);
    enc_eop_d     = (state_d == ST_EOP_SE0);
    enc_idle_d    = (state_d == ST_IDLE) || (state_d == ST_EOP_J);
    tx_busy_d     = (state_d != ST_IDLE);
    tx_done_d     = (state_d == ST_EOP_J) && (cnt_d == CNT_MAX) && !abort_d;
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= {CW{1'b0}};
      idx_q         <= 3'd0;
      shreg_q       <= 8'h00;
      last_q        <= 1'b0;
      ones_q        <= {OW{1'b0}};
      fin_q         <= 1'b0;
      abort_q       <= 1'b0;
      enc_data_q    <= 1'b1;
      enc_new_bit_q <= 1'b0;
      enc_eop_q     <= 1'b0;
      enc_idle_q    <= 1'b1;
      tx_busy_q     <= 1'b0;
      tx_done_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      shreg_q       <= shreg_d;
      last_q        <= last_d;
      ones_q        <= ones_d;
      fin_q         <= fin_d;
      abort_q       <= abort_d;
      enc_data_q    <= enc_data_d;
      enc_new_bit_q <= enc_new_bit_d;
      enc_eop_q     <= enc_eop_d;
      enc_idle_q    <= enc_idle_d;
      tx_busy_q     <= tx_busy_d;
      tx_done_q     <= tx_done_d;
    end
  end

  // Pop and abort strobes depend on tx_valid_i in the very cycle the byte is
  // taken, so they come straight from the registered state and the inputs.
  assign tx_ready_o    = pop_s;
  assign tx_error_o    = err_s;
  assign enc_data_o    = enc_data_q;
  assign enc_new_bit_o = enc_new_bit_q;
  assign enc_eop_o     = enc_eop_q;
  assign enc_idle_o    = enc_idle_q;
  assign tx_busy_o     = tx_busy_q;
  assign tx_done_o     = tx_done_q;

endmodule

// File: tb/tb_usb_tx_controller.sv
// -----------------------------------------------------------------------------
// tb_usb_tx_controller
//
// Self-checking bench for usb_tx_controller. A behavioural model turns each
// packet (byte list + underflow flag) into a list of bit slots (SYNC bits,
// data bits, inserted stuff bits, SE0, SE0, J) and expands that into the
// expected output vector for every clock from the start-accept cycle onward.
// The bench also acts as the byte source, popping on tx_ready.
// Output vector order: {ready, data, new_bit, eop, idle, busy, done, error}.
// -----------------------------------------------------------------------------
module tb_usb_tx_controller;

  localparam int CPB = 4;
  localparam int SL  = 6;
  localparam logic [7:0] IDLE_V   = 8'b0100_1000;
  localparam logic [7:0] ACCEPT_V = 8'b1100_1000;
  localparam int K_BIT = 0;
  localparam int K_SE0 = 1;
  localparam int K_J   = 2;

  typedef struct {
    int kind;
    bit b;
    bit rdy;
    bit err;
  } slot_t;

  logic       clk;
  logic       n_rst;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_last;
  logic       tx_ready;
  logic       enc_data;
  logic       enc_new_bit;
  logic       enc_eop;
  logic       enc_idle;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_error;

  int         n_tests;
  int         n_fail;
  logic [7:0] pkt[$];
  logic [7:0] src_q[$];
  logic [7:0] tr[$];
  bit         src_last;
  bit         pop_pend;
  bit         start_req;
  int         cyc;
  int         st_nb, st_eop, st_rdy, st_rdy_at, st_done, st_done_at, st_err, st_err_at;
  logic [31:0] st_bits;

  usb_tx_controller #(.CLKS_PER_BIT(CPB), .STUFF_LIMIT(SL)) dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .tx_start_i    (tx_start),
    .tx_data_i     (tx_data),
    .tx_valid_i    (tx_valid),
    .tx_last_i     (tx_last),
    .tx_ready_o    (tx_ready),
    .enc_data_o    (enc_data),
    .enc_new_bit_o (enc_new_bit),
    .enc_eop_o     (enc_eop),
    .enc_idle_o    (enc_idle),
    .tx_busy_o     (tx_busy),
    .tx_done_o     (tx_done),
    .tx_error_o    (tx_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] act_v();
    return {tx_ready, enc_data, enc_new_bit, enc_eop, enc_idle, tx_busy, tx_done, tx_error};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural model: slot list from the packet, then one vector per clock.
  function automatic void build_trace(input bit under);
    slot_t s[$];
    slot_t x;
    int ones;
    int nb;
    bit endb;
    logic [7:0] sync_b;
    logic [7:0] v;
    sync_b = 8'h80;
    ones = 0;
    nb = pkt.size();
    tr.delete();
    for (int i = 0; i < 8; i++) begin
      x.kind = K_BIT; x.b = sync_b[i]; x.rdy = 1'b0; x.err = 1'b0;
      s.push_back(x);
      ones = x.b ? ones + 1 : 0;
      if (ones == SL) begin
        ones = 0; x.b = 1'b0; s.push_back(x);
      end
    end
    for (int k = 0; k < nb; k++) begin
      for (int j = 0; j < 8; j++) begin
        endb   = (j == 7) && (k == nb - 1);
        x.kind = K_BIT;
        x.b    = pkt[k][j];
        x.rdy  = (j == 7) && (k < nb - 1);
        x.err  = endb && under;
        s.push_back(x);
        ones = x.b ? ones + 1 : 0;
        if (ones == SL) begin
          ones = 0;
          if (!(endb && under)) begin
            x.b = 1'b0; x.rdy = 1'b0; x.err = 1'b0;
            s.push_back(x);
          end
        end
      end
    end
    x.b = 1'b1; x.rdy = 1'b0; x.err = 1'b0;
    x.kind = K_SE0; s.push_back(x); s.push_back(x);
    x.kind = K_J;   s.push_back(x);
    tr.push_back(ACCEPT_V);
    foreach (s[i]) begin
      for (int o = 0; o < CPB; o++) begin
        v[7] = s[i].rdy && (o == CPB - 1);
        v[6] = (s[i].kind == K_BIT) ? s[i].b : 1'b1;
        v[5] = (s[i].kind == K_BIT) && (o == CPB - 1);
        v[4] = (s[i].kind == K_SE0);
        v[3] = (s[i].kind == K_J);
        v[2] = 1'b1;
        v[1] = (s[i].kind == K_J) && (o == CPB - 1) && !under;
        v[0] = s[i].err && (o == CPB - 1);
        tr.push_back(v);
      end
    end
  endfunction

  // One clock: act as the byte source, drive inputs, sample and compare.
  task automatic tick(input bit chk, input logic [7:0] ev, input string tag);
    logic [7:0] act;
    @(posedge clk);
    #1;
    if (pop_pend && (src_q.size() > 0)) void'(src_q.pop_front());
    tx_start = start_req;
    tx_valid = (src_q.size() > 0);
    if (src_q.size() > 0) begin
      tx_data = src_q[0];
      tx_last = src_last && (src_q.size() == 1);
    end else begin
      tx_data = 8'($urandom);
      tx_last = 1'b0;
    end
    @(negedge clk);
    act = act_v();
    pop_pend = tx_ready;
    if (enc_new_bit) begin
      if (st_nb < 32) st_bits[st_nb] = enc_data;
      st_nb++;
    end
    if (enc_eop) st_eop++;
    if (tx_ready) begin st_rdy++; st_rdy_at = cyc; end
    if (tx_done) begin st_done++; st_done_at = cyc; end
    if (tx_error) begin st_err++; st_err_at = cyc; end
    if (chk) begin
      n_tests++;
      if (act !== ev) begin
        n_fail++;
        $display("FAIL %s cyc=%0d: got %b expected %b (ready,data,new_bit,eop,idle,busy,done,error)",
                 tag, cyc, act, ev);
      end
    end
    cyc++;
  endtask

  task automatic clear_stats();
    st_nb = 0; st_eop = 0; st_rdy = 0; st_rdy_at = -1; st_done = 0; st_done_at = -1;
    st_err = 0; st_err_at = -1; st_bits = 32'h0; cyc = 0;
  endtask

  task automatic send_pkt(input bit under, input bit noise, input string tag);
    build_trace(under);
    src_q = pkt;
    src_last = !under;
    pop_pend = 1'b0;
    clear_stats();
    foreach (tr[i]) begin
      if (i == 0) start_req = 1'b1;
      else start_req = noise && ($urandom_range(0, 1) == 1);
      tick(1'b1, tr[i], tag);
    end
    start_req = 1'b0;
    tick(1'b1, IDLE_V, tag);
  endtask

  initial begin
    int nb;
    int gap;
    bit under;
    bit noise;
    n_tests = 0; n_fail = 0;
    tx_start = 1'b0; tx_valid = 1'b0; tx_last = 1'b0; tx_data = 8'h00;
    start_req = 1'b0; pop_pend = 1'b0; src_last = 1'b0;
    clear_stats();
    n_rst = 1'b0;
    #12;
    check("reset_values", act_v(), IDLE_V);
    @(negedge clk);
    n_rst = 1'b1;
    tick(1'b1, IDLE_V, "idle_after_reset");
    start_req = 1'b1;
    tick(1'b1, IDLE_V, "start_without_valid");
    start_req = 1'b0;

    // Single 0x00, last.
    pkt = '{8'h00};
    send_pkt(1'b0, 1'b0, "pkt_00");
    check("model_len_00", tr.size(), 77);
    check("strobes_00", st_nb, 16);
    check("eop_clks_00", st_eop, 8);
    check("done_at_00", st_done_at, 76);
    check("ready_cnt_00", st_rdy, 1);

    // Single 0xFF: stuff after SYNC 1 + five data 1s.
    pkt = '{8'hFF};
    send_pkt(1'b0, 1'b0, "pkt_ff");
    check("model_len_ff", tr.size(), 81);
    check("strobes_ff", st_nb, 17);
    check("done_at_ff", st_done_at, 80);
    check("stuff_bit_ff", st_bits[13], 1'b0);
    check("bits_ff", st_bits[16:8], 9'h1DF);

    // Two bytes back to back.
    pkt = '{8'hA5, 8'h3C};
    send_pkt(1'b0, 1'b0, "pkt_a5_3c");
    check("stream_a5_3c", st_bits[23:8], 16'h3CA5);
    check("ready_cnt_a5_3c", st_rdy, 2);
    check("ready_at_a5_3c", st_rdy_at, 64);

    // Underflow after 0x12 (not last).
    pkt = '{8'h12};
    send_pkt(1'b1, 1'b0, "pkt_underflow");
    check("err_cnt_uf", st_err, 1);
    check("err_at_uf", st_err_at, 64);
    check("done_cnt_uf", st_done, 0);
    check("eop_clks_uf", st_eop, 8);

    // tx_start noise while busy (including EOP) is ignored.
    pkt = '{8'h5A, 8'hC1};
    send_pkt(1'b0, 1'b1, "pkt_start_noise");
    check("done_cnt_noise", st_done, 1);

    // Reset in DATA slot 3, then a fresh packet with a full SYNC.
    pkt = '{8'hC3};
    build_trace(1'b0);
    src_q = pkt; src_last = 1'b1; pop_pend = 1'b0;
    clear_stats();
    for (int i = 0; i <= 45; i++) begin
      start_req = (i == 0);
      tick(1'b1, tr[i], "pre_reset");
    end
    start_req = 1'b0;
    n_rst = 1'b0;
    #1;
    check("reset_mid_packet", act_v(), IDLE_V);
    @(negedge clk);
    check("reset_held", act_v(), IDLE_V);
    n_rst = 1'b1;
    src_q.delete();
    pop_pend = 1'b0;
    tick(1'b1, IDLE_V, "idle_post_reset");
    pkt = '{8'h81};
    send_pkt(1'b0, 1'b0, "pkt_post_reset");
    check("sync_post_reset", st_bits[7:0], 8'h80);

    // Randomised packets.
    for (int p = 0; p < 40; p++) begin
      nb = $urandom_range(1, 4);
      pkt.delete();
      for (int k = 0; k < nb; k++) begin
        if ($urandom_range(0, 2) == 0) pkt.push_back(8'hFF);
        else pkt.push_back(8'($urandom));
      end
      under = ($urandom_range(0, 3) == 0);
      noise = ($urandom_range(0, 1) == 1);
      send_pkt(under, noise, "rand_pkt");
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        start_req = ($urandom_range(0, 1) == 1);
        tick(1'b1, IDLE_V, "rand_gap");
      end
      start_req = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/usb_tx_controller.md
# usb_tx_controller

Sequences the USB transmit encoder (NRZI, J/K/SE0 line driver) for one packet at a time. It paces bit slots with a clock-divided bit timer and emits the SYNC pattern. It pulls payload bytes from the upstream byte source and serialises them LSB-first with bit stuffing, then drives EOP (two SE0 slots plus one J slot). It sits between the transmit byte FIFO / packet FSM and the encoder, and drives the encoder's data, new-bit, eop and idle inputs.

## Interface
- CLKS_PER_BIT, 8, clocks per USB bit slot (≥ 2)
- STUFF_LIMIT, 6, consecutive transmitted 1s that force a stuffed 0
- clk  in  1  system clock
- n_rst  in  1  asynchronous, active-low reset
- tx_start  in  1  request to send a packet; sampled only in IDLE
- tx_data  in  8  payload byte from source
- tx_valid  in  1  tx_data/tx_last valid
- tx_last  in  1  current byte is the final payload byte
- tx_ready  out  1  one-clock pop strobe; byte latched this cycle
- enc_data  out  1  bit presented to encoder (0 = toggle line)
- enc_new_bit  out  1  one-clock strobe on the final clock of each SYNC/DATA/STUFF slot
- enc_eop  out  1  force SE0 on encoder
- enc_idle  out  1  force J on encoder
- tx_busy  out  1  packet in progress
- tx_done  out  1  one-clock strobe, packet finished normally
- tx_error  out  1  one-clock strobe, underflow abort

## Operation
- States: IDLE, SYNC, DATA, STUFF, EOP_SE0, EOP_J.
- IDLE: enc_idle=1, counters cleared. If tx_start=1 and tx_valid=1: latch tx_data and tx_last into the shift register, pulse tx_ready, go to SYNC. tx_start with tx_valid=0 is ignored.
- Bit timer: counts 0..CLKS_PER_BIT-1 in every non-IDLE state and restarts at 0 on each state entry from IDLE. Slot end = count at CLKS_PER_BIT-1.
- SYNC: sends 8 bits 0,0,0,0,0,0,0,1 (0x80 LSB-first). At the end of the 8th slot go to DATA.
- DATA: enc_data = shreg[0]. At slot end, shift right and increment bit index. After bit 7:
  - if the byte was last, go EOP_SE0 (via STUFF if required);
  - else if tx_valid=1, latch the next byte, pulse tx_ready, stay in DATA;
  - else pulse tx_error and go EOP_SE0.
- Ones counter: increments on each slot end with transmitted bit 1 (including the SYNC final 1), clears on any transmitted 0. When it reaches STUFF_LIMIT at a slot end, the next slot is STUFF.
- STUFF: enc_data=0 for one slot. The shift register and bit index are held; the ones counter is cleared. Then resume DATA, or go EOP_SE0 if the stuff followed the final bit of the last byte.
- EOP_SE0: enc_eop=1 for 2 slots, enc_new_bit=0.
- EOP_J: enc_idle=1 for 1 slot. At slot end, pulse tx_done (unless aborted), go IDLE.
- tx_busy=1 in every state except IDLE.
- enc_data is 1 whenever not in SYNC/DATA/STUFF.

## Timing
- Reset values: state IDLE, tx_ready=0, enc_data=1, enc_new_bit=0, enc_eop=0, enc_idle=1, tx_busy=0, tx_done=0, tx_error=0.
- Reset mid-packet returns to IDLE immediately (async). The encoder returns to J on the same reset.
- The start-accept cycle is IDLE. SYNC slot 0 starts on the next clock.
- enc_new_bit is asserted exactly once per SYNC/DATA/STUFF slot, on its last clock. The encoder line changes at that edge.
- Packet with N bytes and S stuffed bits: (8 + 8N + S + 3)·CLKS_PER_BIT clocks from the first SYNC clock to the tx_done clock, inclusive.
- tx_ready for byte k+1 coincides with the enc_new_bit of byte k's bit 7. If byte k's bit 7 triggers a stuff, the pop still occurs at that slot end.
- tx_start while busy is ignored. After tx_done, a new packet is accepted no earlier than the next clock.
- tx_done and tx_error are mutually exclusive.

## Test plan
- CLKS_PER_BIT=4, single byte 0x00, last=1:
  - 16 enc_new_bit strobes;
  - enc_eop high 8 clocks, then enc_idle;
  - tx_done 76 clocks after start accept;
  - one tx_ready.
- Single byte 0xFF, last=1:
  - SYNC's final 1 plus 5 data 1s triggers a STUFF slot with enc_data=0, then 3 more 1s;
  - 17 strobes total;
  - tx_done after 80 clocks.
- Two bytes 0xA5, 0x3C with tx_valid held high:
  - tx_ready at start accept and at byte 1 bit 7 slot end;
  - serial stream is LSB-first 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0.
- Underflow: byte 0x12 with last=0, then tx_valid=0 at the boundary:
  - tx_error pulse;
  - EOP sequence follows;
  - no tx_done;
  - IDLE afterwards.
- Reset asserted in DATA slot 3:
  - all outputs at reset values within the same cycle;
  - a subsequent tx_start sends a full SYNC.
- tx_start pulsed during EOP_SE0 is ignored; tx_busy drops only after the EOP_J slot.
